// File: rtl/secuenciador_rtc_if.sv
// Read bus between the readout sequencer and the RTC interface.
// Single outstanding request with a level handshake: the master holds req/addr
// until ack is seen, and data_in is valid on the edge where ack is high.
interface secuenciador_rtc_if;
    logic       req;
    logic [7:0] addr;
    logic       ack;
    logic [7:0] data_in;

    modport master (output req, output addr, input ack, input data_in);
    modport slave  (input req, input addr, output ack, output data_in);
endinterface

// File: rtl/secuenciador_rtc.sv
// RTC readout sequencer: walks the fixed RTC address table, issues one bus read
// per register and loads each returned byte into the register bank through the
// shared 'entrada' bus with a one-cycle enable. Reads that are not acknowledged
// within TIMEOUT cycles are abandoned and flagged in 'error'.
module secuenciador_rtc #(
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      modo,
    secuenciador_rtc_if.master        bus,
    output logic [7:0]                entrada,
    output logic                      en_seg,
    output logic                      en_min,
    output logic                      en_hora,
    output logic                      en_dia,
    output logic                      en_mes,
    output logic                      en_anio,
    output logic                      en_seg_tim,
    output logic                      en_min_tim,
    output logic                      en_hora_tim,
    output logic                      busy,
    output logic                      done,
    output logic [8:0]                error
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_LOAD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Last counter value of a read: a timed-out read spans exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
    // Both modes end on hora_tim; the mode only selects the starting index.
    localparam logic [3:0] IDX_LAST = 4'd8;
    localparam logic [3:0] IDX_FULL = 4'd0;
    localparam logic [3:0] IDX_TIM  = 4'd6;

    // RTC address for each bank index, in readout order.
    function automatic logic [7:0] addr_of(input logic [3:0] i);
        logic [7:0] a;
        case (i)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h41;
            4'd7:    a = 8'h42;
            4'd8:    a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    state_t     state_q;
    logic [3:0] idx_q;
    logic [7:0] cnt_q;
    logic       req_q;
    logic [7:0] addr_q;
    logic [7:0] entrada_q;
    logic [8:0] en_q;
    logic       busy_q;
    logic       done_q;
    logic [8:0] error_q;

    logic [3:0] idx_d;
    logic [7:0] addr_d;
    logic [3:0] idx_start_d;
    logic       last_s;
    logic       expired_s;

    // Next-index helpers shared by the timeout and load transitions.
    always_comb begin
        idx_d       = idx_q + 4'd1;
        addr_d      = addr_of(idx_d);
        idx_start_d = modo ? IDX_TIM : IDX_FULL;
        last_s      = (idx_q == IDX_LAST);
        expired_s   = (cnt_q == CNT_LAST);
    end

    // Sequencer FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 8'd0;
            req_q     <= 1'b0;
            addr_q    <= 8'h00;
            entrada_q <= 8'h00;
            en_q      <= 9'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 9'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    en_q   <= 9'd0;
                    done_q <= 1'b0;
                    if (start) begin
                        idx_q   <= idx_start_d;
                        addr_q  <= addr_of(idx_start_d);
                        cnt_q   <= 8'd0;
                        error_q <= 9'd0;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_REQ;
                    end else begin
                        req_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // ack takes priority over an expiring counter on the same edge
                    if (bus.ack) begin
                        entrada_q <= bus.data_in;
                        en_q      <= 9'd1 << idx_q;
                        req_q     <= 1'b0;
                        state_q   <= S_LOAD;
                    end else if (expired_s) begin
                        error_q <= error_q | (9'd1 << idx_q);
                        if (last_s) begin
                            req_q   <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            // req stays high; only the address moves on
                            idx_q   <= idx_d;
                            addr_q  <= addr_d;
                            cnt_q   <= 8'd0;
                            state_q <= S_REQ;
                        end
                    end else begin
                        cnt_q   <= cnt_q + 8'd1;
                        state_q <= S_REQ;
                    end
                end
                S_LOAD: begin
                    en_q <= 9'd0;
                    if (last_s) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= idx_d;
                        addr_q  <= addr_d;
                        cnt_q   <= 8'd0;
                        req_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    req_q   <= 1'b0;
                    en_q    <= 9'd0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req     = req_q;
    assign bus.addr    = addr_q;
    assign entrada     = entrada_q;
    assign en_seg      = en_q[0];
    assign en_min      = en_q[1];
    assign en_hora     = en_q[2];
    assign en_dia      = en_q[3];
    assign en_mes      = en_q[4];
    assign en_anio     = en_q[5];
    assign en_seg_tim  = en_q[6];
    assign en_min_tim  = en_q[7];
    assign en_hora_tim = en_q[8];
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_secuenciador_rtc.sv
// Directed bench for secuenciador_rtc with an RTC responder model and a
// scoreboard of expected bank loads (index, byte) checked as enables appear.
module tb_secuenciador_rtc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       modo;
    logic [7:0] entrada;
    logic       en_seg, en_min, en_hora, en_dia, en_mes, en_anio;
    logic       en_seg_tim, en_min_tim, en_hora_tim;
    logic       busy;
    logic       done;
    logic [8:0] error;

    secuenciador_rtc_if bus ();

    secuenciador_rtc #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .modo        (modo),
        .bus         (bus),
        .entrada     (entrada),
        .en_seg      (en_seg),
        .en_min      (en_min),
        .en_hora     (en_hora),
        .en_dia      (en_dia),
        .en_mes      (en_mes),
        .en_anio     (en_anio),
        .en_seg_tim  (en_seg_tim),
        .en_min_tim  (en_min_tim),
        .en_hora_tim (en_hora_tim),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    wire [8:0] en_s = {en_hora_tim, en_min_tim, en_seg_tim, en_anio, en_mes,
                       en_dia, en_hora, en_min, en_seg};

    // RTC responder: acks after 'lat' wait cycles on an address, never for nack_addr.
    int         lat       = 0;
    logic [7:0] nack_addr = 8'hFF;
    logic       force_ack = 1'b0;
    logic [7:0] last_addr = 8'h00;
    int         wait_cnt  = 0;
    int         eff_wait;

    always_comb eff_wait = (bus.addr == last_addr) ? wait_cnt : 0;
    assign bus.ack     = force_ack | (bus.req & (bus.addr != nack_addr) & (eff_wait == lat));
    assign bus.data_in = bus.addr + 8'h10;

    always @(posedge clk) begin
        last_addr <= bus.addr;
        if (bus.req && !bus.ack) wait_cnt <= eff_wait + 1;
        else                     wait_cnt <= 0;
    end

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0, busy_cnt = 0, req23_cnt = 0, low_addr_cnt = 0, en_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] tb_addr(input int i);
        return (i < 6) ? 8'(8'h21 + i) : 8'(8'h41 + (i - 6));
    endfunction

    task automatic push_range(input int lo, input int hi, input int skip);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            if (i != skip) begin
                e.idx  = 4'(i);
                e.data = tb_addr(i) + 8'h10;
                sb.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: counts activity and pops the scoreboard on every bank load.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
        if (bus.req === 1'b1 && bus.addr == 8'h23) req23_cnt++;
        if (bus.req === 1'b1 && bus.addr < 8'h41) low_addr_cnt++;
        if (en_s != 9'd0) begin
            en_cnt++;
            chk("en_onehot", $countones(en_s), 1);
            chk("req_low_in_load", bus.req, 0);
            if (sb.size() == 0) begin
                chk("en_unexpected", en_s, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("en_which", en_s, 9'd1 << mon_e.idx);
                chk("entrada", entrada, mon_e.data);
            end
        end
    end

    task automatic run_seq(input logic m, input logic [7:0] first_addr, output int n);
        busy_cnt = 0; done_cnt = 0; req23_cnt = 0; low_addr_cnt = 0;
        start = 1'b1;
        modo  = m;
        @(posedge clk);
        #1 start = 1'b0;
        tick();
        n = 1;
        chk("first_req", bus.req, 1);
        chk("first_busy", busy, 1);
        chk("first_addr", bus.addr, first_addr);
        while (done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", done, 1);
        tick();
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"}, bus.req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_en"}, en_s, 0);
        chk({tag, "_addr"}, bus.addr, 8'h00);
        chk({tag, "_entrada"}, entrada, 8'h00);
        chk({tag, "_error"}, error, 9'd0);
    endtask

    initial begin
        int n;
        int en_snap;
        reset = 1'b0; start = 1'b0; modo = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");
        reset = 1'b1;
        tick();

        // Full read, immediate ack
        lat = 0;
        push_range(0, 8, -1);
        run_seq(1'b0, 8'h21, n);
        chk("full_done_cycle", n, 19);
        chk("full_busy_cycles", busy_cnt, 19);
        chk("full_error", error, 9'd0);
        chk("full_sb_empty", sb.size(), 0);
        chk("full_done_count", done_cnt, 1);

        // Timer-only read, ack after two wait cycles
        lat = 2;
        push_range(6, 8, -1);
        run_seq(1'b1, 8'h41, n);
        chk("tim_done_cycle", n, 13);
        chk("tim_busy_cycles", busy_cnt, 13);
        chk("tim_no_date_addr", low_addr_cnt, 0);
        chk("tim_error", error, 9'd0);
        chk("tim_sb_empty", sb.size(), 0);

        // Timeout on hora
        lat = 0;
        nack_addr = 8'h23;
        push_range(0, 8, 2);
        run_seq(1'b0, 8'h21, n);
        chk("to_error", error, 9'b000000100);
        chk("to_req_cycles_0x23", req23_cnt, 4);
        chk("to_done_cycle", n, 21);
        chk("to_sb_empty", sb.size(), 0);
        nack_addr = 8'hFF;

        // ack on the same edge as counter expiry
        lat = 3;
        push_range(6, 8, -1);
        run_seq(1'b1, 8'h41, n);
        chk("race_error", error, 9'd0);
        chk("race_done_cycle", n, 16);
        chk("race_sb_empty", sb.size(), 0);

        // start pulsed while busy is ignored
        lat = 0;
        push_range(6, 8, -1);
        done_cnt = 0;
        start = 1'b1; modo = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("busy_start_done_count", done_cnt, 1);
        chk("busy_start_sb_empty", sb.size(), 0);
        chk("busy_start_idle", busy, 0);

        // Spurious ack in IDLE
        en_snap = en_cnt;
        force_ack = 1'b1;
        repeat (3) tick();
        force_ack = 1'b0;
        tick();
        chk("spurious_no_en", en_cnt, en_snap);
        chk("spurious_req", bus.req, 0);
        chk("spurious_busy", busy, 0);

        // Reset after three loads, with the fourth read being acked
        lat = 0;
        push_range(0, 2, -1);
        done_cnt = 0;
        start = 1'b1; modo = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_three_loads", sb.size(), 0);
        tick();
        chk("mid_fourth_req", bus.addr, 8'h24);
        en_snap = en_cnt;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        chk_reset_vals("mid");
        repeat (3) tick();
        chk("mid_no_fourth_en", en_cnt, en_snap);
        chk("mid_no_done", done_cnt, 0);

        push_range(6, 8, -1);
        run_seq(1'b1, 8'h41, n);
        chk("post_rst_done_cycle", n, 7);
        chk("post_rst_error", error, 9'd0);
        chk("post_rst_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
